insn_decode: RTL and testbench

INSN_DECODE -- requirements
Module: insn_decode

---
 rtl/rv_pkg.sv | 34 +++
 rtl/insn_decode_regfile.sv | 41 ++++
 rtl/insn_decode.sv | 132 +++++++++++++
 tb/tb_insn_decode.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the decode and execute stages.
//
// Contents:
//   OP_*        major opcodes recognised by the pipeline
//   NUM_REGS    number of architectural integer registers
//   reg_idx_t   5-bit register index
//   decode_imm  immediate extraction by major opcode
package rv_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  // U-type keeps the raw upper 20 bits; I-type 12-bit immediates are
  // zero-extended here and sign handling is left to the execute stage.
  function automatic logic [19:0] decode_imm(input logic [31:0] word);
    logic [19:0] result;
    result = '0;
    case (word[6:0])
      OP_LUI, OP_AUIPC:        result = word[31:12];
      OP_IMM, OP_LOAD, OP_JALR: result = {8'b0, word[31:20]};
      default:                 result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/insn_decode_regfile.sv
// Integer register file: 32 x XLEN, two combinational read ports and one
// synchronous write port. x0 always reads 0 and never stores a write.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset (clears all)
//   wr_en, wr_idx, wr_data write port, ignored while rst_n=0
//   rd_idx_a, rd_data_a    read port A
//   rd_idx_b, rd_data_b    read port B
module regfile
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  reg_idx_t        wr_idx,
  input  logic [XLEN-1:0] wr_data,
  input  reg_idx_t        rd_idx_a,
  output logic [XLEN-1:0] rd_data_a,
  input  reg_idx_t        rd_idx_b,
  output logic [XLEN-1:0] rd_data_b
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Reset takes priority so a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data_a = (rd_idx_a == '0) ? '0 : regs[rd_idx_a];
  assign rd_data_b = (rd_idx_b == '0) ? '0 : regs[rd_idx_b];

endmodule

// File: rtl/insn_decode.sv
// RV32 decode stage with a one-entry output register and valid/ready
// handshakes on both sides. Operands are read from the register file at
// accept, with same-cycle write-back forwarding, and a held bundle keeps
// tracking write-backs to its source registers until it is consumed.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_ready, insn   fetch side handshake and instruction word
//   out_valid, out_ready       execute side handshake
//   opcode, funct3, funct7,
//   imm, rd_idx, rs1, rs2      decoded bundle
//   wb_en, wb_idx, wb_data     register-file write port from execute
//   illegal                    only when INSN_DECODE_ILLEGAL_EN is defined:
//                              unsupported opcode / R-type funct7
module insn_decode
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [19:0]     imm,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [4:0]      rd_idx,
  input  logic            wb_en,
  input  reg_idx_t        wb_idx,
  input  logic [XLEN-1:0] wb_data
`ifdef INSN_DECODE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic            accept;
  reg_idx_t        src1;
  reg_idx_t        src2;
  reg_idx_t        held_src1;
  reg_idx_t        held_src2;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign src1     = insn[19:15];
  assign src2     = insn[24:20];

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_en),
    .wr_idx    (wb_idx),
    .wr_data   (wb_data),
    .rd_idx_a  (src1),
    .rd_data_a (rf_a),
    .rd_idx_b  (src2),
    .rd_data_b (rf_b)
  );

  // The array only updates at the clock edge, so a write landing in the
  // accept cycle must be bypassed for the bundle to see the new value.
  assign op_a = (wb_en && (wb_idx == src1) && (src1 != '0)) ? wb_data : rf_a;
  assign op_b = (wb_en && (wb_idx == src2) && (src2 != '0)) ? wb_data : rf_b;

`ifdef INSN_DECODE_ILLEGAL_EN
  logic illegal_next;

  always_comb begin
    illegal_next = 1'b1;
    case (insn[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_LOAD, OP_JALR: illegal_next = 1'b0;
      OP_REG: illegal_next = !((insn[31:25] == 7'b0000000) ||
                               (insn[31:25] == 7'b0100000));
      default: illegal_next = 1'b1;
    endcase
  end
`endif

  // A stalled bundle snoops write-backs so its operands never go stale
  // while execute is not ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      funct3    <= '0;
      funct7    <= '0;
      imm       <= '0;
      rd_idx    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      held_src1 <= '0;
      held_src2 <= '0;
`ifdef INSN_DECODE_ILLEGAL_EN
      illegal   <= 1'b0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode    <= insn[6:0];
      funct3    <= insn[14:12];
      funct7    <= insn[31:25];
      imm       <= decode_imm(insn);
      rd_idx    <= insn[11:7];
      rs1       <= op_a;
      rs2       <= op_b;
      held_src1 <= src1;
      held_src2 <= src2;
`ifdef INSN_DECODE_ILLEGAL_EN
      illegal   <= illegal_next;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (wb_en && (wb_idx == held_src1) && (held_src1 != '0)) begin
        rs1 <= wb_data;
      end
      if (wb_en && (wb_idx == held_src2) && (held_src2 != '0)) begin
        rs2 <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_insn_decode.sv
// Directed self-checking bench for insn_decode (XLEN=32). Inputs are driven
// on the falling edge, outputs checked on the following falling edge.
// Define INSN_DECODE_ILLEGAL_EN for both bench and RTL to cover illegal.
module tb_insn_decode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [19:0] imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_idx;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
`ifdef INSN_DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  insn_decode #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .insn      (insn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd_idx    (rd_idx),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data)
`ifdef INSN_DECODE_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] word,
                               input logic ordy, input logic we,
                               input logic [4:0] widx, input logic [31:0] wdata);
    in_valid  = v;
    insn      = word;
    out_ready = ordy;
    wb_en     = we;
    wb_idx    = widx;
    wb_data   = wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_opcode",    64'(opcode),    64'd0);
    checkOutput("reset_rs1",       64'(rs1),       64'd0);
    rst_n = 1'b1;

    // LUI x1, 0x12345
    applyStimulus(1'b1, 32'h123450B7, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("lui_out_valid", 64'(out_valid), 64'd1);
    checkOutput("lui_opcode",    64'(opcode),    64'h37);
    checkOutput("lui_imm",       64'(imm),       64'h12345);
    checkOutput("lui_rd",        64'(rd_idx),    64'd1);
    checkOutput("lui_funct3",    64'(funct3),    64'd5);

    // ADD x3,x2,x2 with x2<=5 written in the same cycle
    applyStimulus(1'b1, 32'h002101B3, 1'b1, 1'b1, 5'd2, 32'd5);
    tick();
    checkOutput("fwd_rs1",    64'(rs1),    64'd5);
    checkOutput("fwd_rs2",    64'(rs2),    64'd5);
    checkOutput("fwd_rd",     64'(rd_idx), 64'd3);
    checkOutput("fwd_imm",    64'(imm),    64'd0);
    checkOutput("fwd_opcode", 64'(opcode), 64'h33);

    // SUB x4,x1,x2 accepted, then held with out_ready=0
    applyStimulus(1'b1, 32'h40208233, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("sub_rs1", 64'(rs1), 64'd0);
    checkOutput("sub_rs2", 64'(rs2), 64'd5);
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    tick();
    checkOutput("hold_opcode", 64'(opcode), 64'h33);
    checkOutput("hold_funct7", 64'(funct7), 64'h20);
    checkOutput("hold_rd",     64'(rd_idx), 64'd4);
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b1, 5'd1, 32'd7);
    tick();
    checkOutput("hold_wb_rs1",    64'(rs1),       64'd7);
    checkOutput("hold_wb_rs2",    64'(rs2),       64'd5);
    checkOutput("hold_wb_opcode", 64'(opcode),    64'h33);
    checkOutput("hold_wb_funct7", 64'(funct7),    64'h20);
    checkOutput("hold_wb_funct3", 64'(funct3),    64'd0);
    checkOutput("hold_wb_rd",     64'(rd_idx),    64'd4);
    checkOutput("hold_wb_valid",  64'(out_valid), 64'd1);
    checkOutput("hold_wb_ready",  64'(in_ready),  64'd0);

    // Back-to-back stream, x1=7 x2=5
    // ADDI x6,x1,0x7FF (consumes the held SUB in the same cycle)
    applyStimulus(1'b1, 32'h7FF08313, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_addi_rd",  64'(rd_idx), 64'd6);
    checkOutput("b2b_addi_rs1", 64'(rs1),    64'd7);
    checkOutput("b2b_addi_imm", 64'(imm),    64'h007FF);
    // LW x7,0xFFF(x2): 12-bit immediate zero-extended
    applyStimulus(1'b1, 32'hFFF12383, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_lw_rd",     64'(rd_idx), 64'd7);
    checkOutput("b2b_lw_rs1",    64'(rs1),    64'd5);
    checkOutput("b2b_lw_imm",    64'(imm),    64'h00FFF);
    checkOutput("b2b_lw_funct3", 64'(funct3), 64'd2);
    // ADD x8,x1,x2
    applyStimulus(1'b1, 32'h00208433, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_add_rd",  64'(rd_idx), 64'd8);
    checkOutput("b2b_add_rs1", 64'(rs1),    64'd7);
    checkOutput("b2b_add_rs2", 64'(rs2),    64'd5);
    // AUIPC x9,0xFFFFF
    applyStimulus(1'b1, 32'hFFFFF497, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_auipc_rd",  64'(rd_idx), 64'd9);
    checkOutput("b2b_auipc_op",  64'(opcode), 64'h17);
    checkOutput("b2b_auipc_imm", 64'(imm),    64'hFFFFF);
    // JAL x12: not an immediate-carrying opcode here, imm must be 0
    applyStimulus(1'b1, 32'hFFFFF66F, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_jal_rd",    64'(rd_idx),    64'd12);
    checkOutput("b2b_jal_imm",   64'(imm),       64'd0);
    checkOutput("b2b_jal_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("drain_valid", 64'(out_valid), 64'd0);

    // x0 write attempts, then read x0
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFF);
    tick();
    // ADD x10,x0,x1 with another x0 write in the same cycle, held
    applyStimulus(1'b1, 32'h00100533, 1'b0, 1'b1, 5'd0, 32'hFF);
    tick();
    checkOutput("x0_valid", 64'(out_valid), 64'd1);
    checkOutput("x0_rs1",   64'(rs1),       64'd0);
    checkOutput("x0_rs2",   64'(rs2),       64'd7);

    // Reset while a bundle is held; the write of x5 must be ignored
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b1, 5'd5, 32'h99);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_opcode",    64'(opcode),    64'd0);
    checkOutput("rst_funct3",    64'(funct3),    64'd0);
    checkOutput("rst_funct7",    64'(funct7),    64'd0);
    checkOutput("rst_imm",       64'(imm),       64'd0);
    checkOutput("rst_rd",        64'(rd_idx),    64'd0);
    checkOutput("rst_rs1",       64'(rs1),       64'd0);
    checkOutput("rst_rs2",       64'(rs2),       64'd0);

    // ADD x11,x1,x5: register file cleared, x5 never written
    applyStimulus(1'b1, 32'h005085B3, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("post_rst_valid", 64'(out_valid), 64'd1);
    checkOutput("post_rst_rs1",   64'(rs1),       64'd0);
    checkOutput("post_rst_rs2",   64'(rs2),       64'd0);
    checkOutput("post_rst_rd",    64'(rd_idx),    64'd11);

`ifdef INSN_DECODE_ILLEGAL_EN
    applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("illegal_7f", 64'(illegal), 64'd1);
    applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("illegal_add", 64'(illegal), 64'd0);
`endif

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
